// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and widths for the 8:1 round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  // IDLE: nobody owns the mux. BUSY: owner index is frozen until release.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the shared mux.
interface mux_rr_arbiter_if;
  import mux_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             dst_ready;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] ack;
  logic             out_valid;
  logic [CNT_W-1:0] beat_cnt;

  // Requester/consumer side drives requests and readiness.
  modport master (
    output req, dst_ready,
    input  sel, gnt, ack, out_valid, beat_cnt
  );

  // Arbiter side observes requests and owns the grant outputs.
  modport slave (
    input  req, dst_ready,
    output sel, gnt, ack, out_valid, beat_cnt
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping 7->0.
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] pos;

  // Scan offsets from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = ptr + SEL_W'(i);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 datapath mux.
// Optional feature: define ARB_BURST_LIMIT_EN to force release after MAX_BURST
// beats; otherwise grants last until the owner drops its request and the beat
// counter saturates at 15.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux_rr_arbiter_if.slave  bus
);

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("mux_rr_arbiter: MAX_BURST must be within 1..16");
  end

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;

  rr_pick u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register: owner, pointer, beat count and grant all reset together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

  // Next-state logic: arbitrate when idle or on release, otherwise count beats.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    owner_req  = bus.req[owner_q];
    unique case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        owner_d    = '0;
        if (pick_found) begin
          state_d = BUSY;
          owner_d = pick_idx;
          ptr_d   = pick_idx + SEL_W'(1);
        end
      end
      BUSY: begin
        if (!owner_req) begin
          beat_cnt_d = '0;
          if (pick_found) begin
            owner_d = pick_idx;
            ptr_d   = pick_idx + SEL_W'(1);
          end else begin
            state_d = IDLE;
            owner_d = '0;
          end
        end else if (bus.dst_ready) begin
`ifdef ARB_BURST_LIMIT_EN
          if (({1'b0, beat_cnt_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_BURST)) begin
            state_d    = IDLE;
            owner_d    = '0;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
`else
          if (beat_cnt_q != '1) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    gnt_d = (state_d == BUSY) ? (N_REQ'(1) << owner_d) : '0;
  end

  // Output logic: registered grant/select/count, combinational ack and valid.
  always_comb begin
    bus.gnt       = gnt_q;
    bus.sel       = owner_q;
    bus.beat_cnt  = beat_cnt_q;
    bus.out_valid = (state_q == BUSY) && bus.req[owner_q];
    bus.ack       = gnt_q & bus.req & {N_REQ{bus.dst_ready}};
  end

endmodule
